pwm_multi: RTL and testbench



---
 rtl/pwm_multi.sv | 180 ++++++++++++++++++
 tb/tb_pwm_multi.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with per-channel prescaler, period
// and duty, all double-buffered and reloaded at period boundaries.
// Optional feature macro: PWM_CENTER_ALIGN_EN adds mode_i (1 = center-aligned
// up/down counting). Without it every channel counts edge-aligned.
module pwm_multi #(
  parameter int CH_NUM = 3,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [CH_NUM-1:0]             enable_i,
  input  logic [CH_NUM-1:0]             polarity_i,
  input  logic [CH_NUM-1:0]             update_i,
  input  logic [CH_NUM-1:0][PSC_W-1:0]  prescaler_i,
  input  logic [CH_NUM-1:0][CNT_W-1:0]  pwm_period_i,
  input  logic [CH_NUM-1:0][CNT_W-1:0]  duty_cycle_i,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic [CH_NUM-1:0]             mode_i,
`endif
  output logic [CH_NUM-1:0]             pwm_o,
  output logic [CH_NUM-1:0]             period_end_o
);

  // Live mode request; tied to edge-aligned when the feature is absent.
  logic [CH_NUM-1:0] mode_live_s;
`ifdef PWM_CENTER_ALIGN_EN
  assign mode_live_s = mode_i;
`else
  assign mode_live_s = {CH_NUM{1'b0}};
`endif

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic             run_q, run_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [PSC_W-1:0] psc_sh_q, psc_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic             mode_sh_q, mode_sh_d;
    logic             dir_q, dir_d;        // 1 = counting down (center mode)
    logic             pend_q, pend_d;
    logic             pwm_q, pwm_d;
    logic             pe_q, pe_d;
    logic             tick_s;
    logic             load_s;
    logic             wrap_at_tick_s;
    logic [CNT_W-1:0] cnt_step_s;
    logic             dir_step_s;

    assign tick_s = (psc_cnt_q == psc_sh_q);

    // Counter value, direction and wrap flag that the next tick would produce.
    always_comb begin
      cnt_step_s     = cnt_q;
      dir_step_s     = dir_q;
      wrap_at_tick_s = 1'b0;
      if (mode_sh_q) begin
        if (per_sh_q == {CNT_W{1'b0}}) begin
          cnt_step_s     = {CNT_W{1'b0}};
          dir_step_s     = 1'b0;
          wrap_at_tick_s = 1'b1;
        end else if (!dir_q) begin
          if (cnt_q == per_sh_q) begin
            // Turn around at the top; the top value is visited only once.
            cnt_step_s = cnt_q - CNT_W'(1);
            dir_step_s = 1'b1;
          end else begin
            cnt_step_s = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_step_s = cnt_q - CNT_W'(1);
        end
        // Reaching zero while counting down is the period boundary.
        if ((per_sh_q != {CNT_W{1'b0}}) && dir_step_s && (cnt_step_s == {CNT_W{1'b0}})) begin
          wrap_at_tick_s = 1'b1;
          dir_step_s     = 1'b0;
        end else begin
          wrap_at_tick_s = wrap_at_tick_s;
        end
      end else begin
        if (cnt_q == per_sh_q) begin
          cnt_step_s     = {CNT_W{1'b0}};
          wrap_at_tick_s = 1'b1;
        end else begin
          cnt_step_s = cnt_q + CNT_W'(1);
        end
      end
    end

    // Channel next state: idle clearing, start-up load, run and shadow reload.
    always_comb begin
      run_d     = run_q;
      psc_cnt_d = psc_cnt_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      pend_d    = pend_q;
      pwm_d     = pwm_q;
      pe_d      = 1'b0;
      load_s    = 1'b0;
      if (!enable_i[g]) begin
        run_d     = 1'b0;
        psc_cnt_d = {PSC_W{1'b0}};
        cnt_d     = {CNT_W{1'b0}};
        dir_d     = 1'b0;
        pend_d    = 1'b0;
        pwm_d     = polarity_i[g];
      end else if (!run_q) begin
        run_d     = 1'b1;
        load_s    = 1'b1;
        psc_cnt_d = {PSC_W{1'b0}};
        cnt_d     = {CNT_W{1'b0}};
        dir_d     = 1'b0;
        pend_d    = 1'b0;
        pwm_d     = polarity_i[g];
      end else begin
        pwm_d = (cnt_q < duty_sh_q) ^ polarity_i[g];
        if (tick_s) begin
          psc_cnt_d = {PSC_W{1'b0}};
          cnt_d     = cnt_step_s;
          dir_d     = dir_step_s;
          if (wrap_at_tick_s) begin
            pe_d   = 1'b1;
            load_s = pend_q | update_i[g];
            pend_d = 1'b0;
          end else begin
            pend_d = pend_q | update_i[g];
          end
        end else begin
          psc_cnt_d = psc_cnt_q + PSC_W'(1);
          pend_d    = pend_q | update_i[g];
        end
      end
      if (load_s) begin
        psc_sh_d  = prescaler_i[g];
        per_sh_d  = pwm_period_i[g];
        duty_sh_d = duty_cycle_i[g];
        mode_sh_d = mode_live_s[g];
      end else begin
        psc_sh_d  = psc_sh_q;
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        mode_sh_d = mode_sh_q;
      end
    end

    // Channel state registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        run_q     <= 1'b0;
        psc_cnt_q <= {PSC_W{1'b0}};
        psc_sh_q  <= {PSC_W{1'b0}};
        cnt_q     <= {CNT_W{1'b0}};
        per_sh_q  <= {CNT_W{1'b0}};
        duty_sh_q <= {CNT_W{1'b0}};
        mode_sh_q <= 1'b0;
        dir_q     <= 1'b0;
        pend_q    <= 1'b0;
        pwm_q     <= 1'b0;
        pe_q      <= 1'b0;
      end else begin
        run_q     <= run_d;
        psc_cnt_q <= psc_cnt_d;
        psc_sh_q  <= psc_sh_d;
        cnt_q     <= cnt_d;
        per_sh_q  <= per_sh_d;
        duty_sh_q <= duty_sh_d;
        mode_sh_q <= mode_sh_d;
        dir_q     <= dir_d;
        pend_q    <= pend_d;
        pwm_q     <= pwm_d;
        pe_q      <= pe_d;
      end
    end

    assign pwm_o[g]        = pwm_q;
    assign period_end_o[g] = pe_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi. Reference model tracks each channel's
// position inside its period (in clocks) and derives the counter value and
// outputs arithmetically from the configured prescaler/period/duty.
module tb_pwm_multi;
  localparam int CH = 3;
  localparam int CW = 32;
  localparam int PW = 16;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [CH-1:0]         en, pol, upd;
  logic [CH-1:0][PW-1:0] psc;
  logic [CH-1:0][CW-1:0] per, duty;
  logic [CH-1:0]         mode;
  logic [CH-1:0]         pwm, pe;

  int n_tests = 0;
  int n_fail  = 0;

  bit     m_run[CH];
  bit     m_pend[CH];
  bit     m_mode[CH];
  longint m_pos[CH];
  longint m_psc[CH], m_per[CH], m_duty[CH];
  logic [CH-1:0] exp_pwm, exp_pe;

  pwm_multi #(.CH_NUM(CH), .CNT_W(CW), .PSC_W(PW)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .enable_i     (en),
    .polarity_i   (pol),
    .update_i     (upd),
    .prescaler_i  (psc),
    .pwm_period_i (per),
    .duty_cycle_i (duty),
`ifdef PWM_CENTER_ALIGN_EN
    .mode_i       (mode),
`endif
    .pwm_o        (pwm),
    .period_end_o (pe)
  );

  always #5 clk = ~clk;

  // Period length in clocks for the active shadow configuration.
  function automatic longint plen(int c);
    if (m_mode[c])
      return (m_per[c] == 0) ? (m_psc[c] + 1) : (2 * m_per[c] * (m_psc[c] + 1));
    return (m_per[c] + 1) * (m_psc[c] + 1);
  endfunction

  // Counter value held at position m_pos within the period.
  function automatic longint cnt_at(int c);
    longint t;
    t = m_pos[c] / (m_psc[c] + 1);
    if (m_mode[c]) begin
      if (m_per[c] == 0) return 0;
      return (t <= m_per[c]) ? t : (2 * m_per[c] - t);
    end
    return t;
  endfunction

  task automatic model_load(int c);
    m_psc[c]  = longint'(psc[c]);
    m_per[c]  = longint'(per[c]);
    m_duty[c] = longint'(duty[c]);
`ifdef PWM_CENTER_ALIGN_EN
    m_mode[c] = mode[c];
`else
    m_mode[c] = 1'b0;
`endif
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_pend[c] = 0; m_pos[c] = 0;
    end
    exp_pwm = '0;
    exp_pe  = '0;
  endtask

  // Advance the model by one clock edge using the inputs as sampled there.
  task automatic model_edge();
    if (!rstn) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      exp_pe[c] = 1'b0;
      if (!en[c]) begin
        m_run[c] = 0; m_pend[c] = 0; m_pos[c] = 0;
        exp_pwm[c] = pol[c];
      end else if (!m_run[c]) begin
        m_run[c] = 1; m_pend[c] = 0; m_pos[c] = 0;
        model_load(c);
        exp_pwm[c] = pol[c];
      end else begin
        exp_pwm[c] = ((cnt_at(c) < m_duty[c]) ? 1'b1 : 1'b0) ^ pol[c];
        m_pos[c]++;
        if (m_pos[c] >= plen(c)) begin
          m_pos[c] = 0;
          exp_pe[c] = 1'b1;
          if (m_pend[c] || upd[c]) model_load(c);
          m_pend[c] = 0;
        end else begin
          m_pend[c] = m_pend[c] | upd[c];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cfg(int c, int p_psc, int p_per, int p_duty, bit p_pol);
    psc[c]  = PW'(p_psc);
    per[c]  = CW'(p_per);
    duty[c] = CW'(p_duty);
    pol[c]  = p_pol;
  endtask

  task automatic test_reset();
    rstn = 1'b0; pol = 3'b101;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (pwm !== 3'b000 || pe !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_hold: pwm=%b pe=%b expected 000/000", pwm, pe);
      end
      tick();
    end
    rstn = 1'b1;
    tick();
    n_tests++;
    if (pwm !== 3'b101 || pe !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_polarity: pwm=%b pe=%b expected 101/000", pwm, pe);
    end
    pol = 3'b000;
    tick();
  endtask

  task automatic test_edge_basic();
    int hi = 0, pes = 0;
    cfg(0, 0, 9, 3, 1'b0);
    en[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if (pwm !== exp_pwm || pe !== exp_pe) begin
        n_fail++;
        $display("FAIL basic_ch0 i=%0d: pwm=%b pe=%b expected %b/%b", i, pwm, pe, exp_pwm, exp_pe);
      end
      if (i >= 1 && i <= 30) begin hi += pwm[0]; pes += pe[0]; end
    end
    n_tests++;
    if (hi != 9 || pes != 3) begin
      n_fail++;
      $display("FAIL basic_ch0_counts: high=%0d pe=%0d expected 9/3", hi, pes);
    end
  endtask

  task automatic test_ch1_prescaled();
    int lo = 0, pes = 0;
    cfg(1, 3, 4, 2, 1'b1);
    en[1] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_tests++;
      if (pwm !== exp_pwm || pe !== exp_pe) begin
        n_fail++;
        $display("FAIL ch1_psc i=%0d: pwm=%b pe=%b expected %b/%b", i, pwm, pe, exp_pwm, exp_pe);
      end
      if (i >= 1 && i <= 40) begin lo += (pwm[1] == 1'b0); pes += pe[1]; end
    end
    n_tests++;
    if (lo != 16 || pes != 2) begin
      n_fail++;
      $display("FAIL ch1_counts: low=%0d pe=%0d expected 16/2", lo, pes);
    end
    en[1] = 1'b0;
    tick();
  endtask

  task automatic test_boundaries();
    int b_per[3]  = '{9, 9, 0};
    int b_duty[3] = '{0, 11, 3};
    int b_hi[3]   = '{0, 24, 24};
    int b_pe[3]   = '{2, 2, 24};
    for (int k = 0; k < 3; k++) begin
      int hi = 0, pes = 0;
      en[0] = 1'b0;
      tick();
      cfg(0, 0, b_per[k], b_duty[k], 1'b0);
      en[0] = 1'b1;
      for (int i = 0; i < 25; i++) begin
        tick();
        n_tests++;
        if (pwm !== exp_pwm || pe !== exp_pe) begin
          n_fail++;
          $display("FAIL boundary%0d i=%0d: pwm=%b pe=%b expected %b/%b", k, i, pwm, pe, exp_pwm, exp_pe);
        end
        if (i >= 1) begin hi += pwm[0]; pes += pe[0]; end
      end
      n_tests++;
      if (hi != b_hi[k] || pes != b_pe[k]) begin
        n_fail++;
        $display("FAIL boundary%0d_counts: high=%0d pe=%0d expected %0d/%0d", k, hi, pes, b_hi[k], b_pe[k]);
      end
    end
  endtask

  task automatic test_update();
    int hi = 0, gap = 0, found = 0;
    en[0] = 1'b0;
    tick();
    cfg(0, 0, 9, 3, 1'b0);
    en[0] = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    duty[0] = CW'(7);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (pwm !== exp_pwm || pe !== exp_pe) begin
        n_fail++;
        $display("FAIL no_update i=%0d: pwm=%b pe=%b expected %b/%b", i, pwm, pe, exp_pwm, exp_pe);
      end
      hi += pwm[0];
    end
    n_tests++;
    if (hi != 6) begin
      n_fail++;
      $display("FAIL no_update_count: high=%0d expected 6", hi);
    end
    upd[0] = 1'b1;
    tick();
    upd[0] = 1'b0;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_tests++;
      if (pwm !== exp_pwm || pe !== exp_pe) begin
        n_fail++;
        $display("FAIL mid_update k=%0d: pwm=%b pe=%b expected %b/%b", k, pwm, pe, exp_pwm, exp_pe);
      end
      if (k < 4) gap += pwm[0];
      else if (k < 14) hi += pwm[0];
    end
    n_tests++;
    if (gap != 0 || hi != 7) begin
      n_fail++;
      $display("FAIL mid_update_counts: gap=%0d high=%0d expected 0/7", gap, hi);
    end
    duty[0] = CW'(5);
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_pos[0] == plen(0) - 1) found = 1;
      else tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL wrap_search: found=0 expected 1");
    end
    upd[0] = 1'b1;
    tick();
    upd[0] = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (pwm !== exp_pwm || pe !== exp_pe) begin
        n_fail++;
        $display("FAIL wrap_update i=%0d: pwm=%b pe=%b expected %b/%b", i, pwm, pe, exp_pwm, exp_pe);
      end
      hi += pwm[0];
    end
    n_tests++;
    if (hi != 5) begin
      n_fail++;
      $display("FAIL wrap_update_count: high=%0d expected 5", hi);
    end
  endtask

  task automatic test_disable();
    int found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_pos[0] == plen(0) - 1) found = 1;
      else tick();
    end
    pol[0] = 1'b1;
    en[0]  = 1'b0;
    tick();
    n_tests++;
    if (!found || pwm[0] !== 1'b1 || pe[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL disable: found=%0d pwm0=%b pe0=%b expected 1/1/0", found, pwm[0], pe[0]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (pwm !== exp_pwm || pe !== exp_pe) begin
        n_fail++;
        $display("FAIL disable_idle i=%0d: pwm=%b pe=%b expected %b/%b", i, pwm, pe, exp_pwm, exp_pe);
      end
    end
    pol[0] = 1'b0;
    tick();
  endtask

  task automatic test_center();
`ifdef PWM_CENTER_ALIGN_EN
    int hi = 0, pes = 0;
    cfg(2, 0, 4, 2, 1'b0);
    mode[2] = 1'b1;
    en[2]   = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      n_tests++;
      if (pwm !== exp_pwm || pe !== exp_pe) begin
        n_fail++;
        $display("FAIL center i=%0d: pwm=%b pe=%b expected %b/%b", i, pwm, pe, exp_pwm, exp_pe);
      end
      if (i >= 1 && i <= 16) begin hi += pwm[2]; pes += pe[2]; end
    end
    n_tests++;
    if (hi != 6 || pes != 2) begin
      n_fail++;
      $display("FAIL center_counts: high=%0d pe=%0d expected 6/2", hi, pes);
    end
    en[2]   = 1'b0;
    mode[2] = 1'b0;
    tick();
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < CH; c++) begin
      cfg(c, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
      mode[c] = 1'($urandom_range(0, 1));
    end
    en = 3'b111;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 99) < 2) en[c] = ~en[c];
        if ($urandom_range(0, 99) < 5)
          cfg(c, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 99) < 3) mode[c] = ~mode[c];
        upd[c] = ($urandom_range(0, 7) == 0);
      end
      tick();
      n_tests++;
      if (pwm !== exp_pwm || pe !== exp_pe) begin
        n_fail++;
        $display("FAIL random i=%0d: pwm=%b pe=%b expected %b/%b", i, pwm, pe, exp_pwm, exp_pe);
      end
    end
    upd = '0;
  endtask

  task automatic test_reset_mid();
    en = 3'b111;
    for (int i = 0; i < 7; i++) tick();
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (pwm !== 3'b000 || pe !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: pwm=%b pe=%b expected 000/000", pwm, pe);
    end
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_tests++;
      if (pwm !== exp_pwm || pe !== exp_pe) begin
        n_fail++;
        $display("FAIL after_reset i=%0d: pwm=%b pe=%b expected %b/%b", i, pwm, pe, exp_pwm, exp_pe);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; en = '0; pol = '0; upd = '0; mode = '0;
    psc = '0; per = '0; duty = '0;
    test_reset();
    test_edge_basic();
    test_ch1_prescaled();
    test_boundaries();
    test_update();
    test_disable();
    test_center();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
